// File: rtl/vga_scan_gen.sv
// vga_scan_gen - raster scan generator for the VGA output path.
//
// Divides clk down to a pixel enable, walks DrawX/DrawY across the full
// raster (visible area plus porches and sync), and produces registered
// hs/vs/blank that line up with the coordinates presented on the same cycle.
// Also emits one-clk frame_start / vblank_start event pulses for the game
// update logic.
//
// Ports:
//   clk           in   system clock (only clock)
//   Reset         in   synchronous, active-high reset
//   pix_en        out  one-clk pulse per pixel; raster advances on it
//   DrawX[9:0]    out  horizontal position, 0..H_TOTAL-1
//   DrawY[9:0]    out  vertical position, 0..V_TOTAL-1
//   hs            out  horizontal sync, active low
//   vs            out  vertical sync, active low
//   blank         out  1 = visible pixel, 0 = blanking interval
//   frame_start   out  pulse on the cycle after the raster enters (0,0)
//   vblank_start  out  pulse on the cycle after the raster enters (0,V_VISIBLE)
//
// Build option:
//   VGA_PIPE_ALIGN_EN - when defined, hs/vs/blank are delayed by one extra
//   pixel (delay stage advances on pix_en) to match a color_mapper with a
//   registered RGB output. Coordinates and event pulses are not delayed.
module vga_scan_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 2
) (
  input  logic       clk,
  input  logic       Reset,
  output logic       pix_en,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       frame_start,
  output logic       vblank_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] V_VIS_LAST = 10'(V_VISIBLE - 1);
  localparam logic [9:0] HS_FIRST   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
  logic             pix_en_reg;
  logic [9:0]       x_reg, x_next;
  logic [9:0]       y_reg, y_next;
  logic             line_end, frame_end, vis_end;
  logic             hs_next, vs_next, blank_next;
  logic             hs_reg, vs_reg, blank_reg;
  logic             frame_start_reg, vblank_start_reg;

  always_comb begin
    div_cnt_next = (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + DIV_ONE;

    line_end  = (x_reg == H_LAST);
    frame_end = pix_en_reg && line_end && (y_reg == V_LAST);
    vis_end   = pix_en_reg && line_end && (y_reg == V_VIS_LAST);

    x_next = x_reg;
    y_next = y_reg;
    if (pix_en_reg) begin
      if (line_end) begin
        x_next = '0;
        y_next = (y_reg == V_LAST) ? '0 : y_reg + 10'd1;
      end else begin
        x_next = x_reg + 10'd1;
      end
    end

    // Decoding the next coordinates lets the registered syncs change on the
    // same edge as DrawX/DrawY, so they never lag the coordinates.
    hs_next    = !((x_next >= HS_FIRST) && (x_next <= HS_LAST));
    vs_next    = !((y_next >= VS_FIRST) && (y_next <= VS_LAST));
    blank_next = (x_next < H_VIS) && (y_next < V_VIS);
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      div_cnt_reg      <= '0;
      pix_en_reg       <= 1'b0;
      x_reg            <= '0;
      y_reg            <= '0;
      hs_reg           <= 1'b1;
      vs_reg           <= 1'b1;
      blank_reg        <= 1'b1;
      frame_start_reg  <= 1'b0;
      vblank_start_reg <= 1'b0;
    end else begin
      div_cnt_reg      <= div_cnt_next;
      // Registered enable: high while div_cnt sits at its last count.
      pix_en_reg       <= (div_cnt_next == DIV_LAST);
      x_reg            <= x_next;
      y_reg            <= y_next;
      hs_reg           <= hs_next;
      vs_reg           <= vs_next;
      blank_reg        <= blank_next;
      frame_start_reg  <= frame_end;
      vblank_start_reg <= vis_end;
    end
  end

  assign pix_en       = pix_en_reg;
  assign DrawX        = x_reg;
  assign DrawY        = y_reg;
  assign frame_start  = frame_start_reg;
  assign vblank_start = vblank_start_reg;

`ifdef VGA_PIPE_ALIGN_EN
  // One-pixel delay stage: captures the previous pixel's sync/blank on each
  // pixel advance, matching a one-pixel registered RGB path downstream.
  logic hs_d_reg, vs_d_reg, blank_d_reg;

  always_ff @(posedge clk) begin
    if (Reset) begin
      hs_d_reg    <= 1'b1;
      vs_d_reg    <= 1'b1;
      blank_d_reg <= 1'b1;
    end else if (pix_en_reg) begin
      hs_d_reg    <= hs_reg;
      vs_d_reg    <= vs_reg;
      blank_d_reg <= blank_reg;
    end
  end

  assign hs    = hs_d_reg;
  assign vs    = vs_d_reg;
  assign blank = blank_d_reg;
`else
  assign hs    = hs_reg;
  assign vs    = vs_reg;
  assign blank = blank_reg;
`endif

endmodule

// File: tb/tb_vga_scan_gen.sv
// Testbench for vga_scan_gen using a reduced raster so several frames fit in
// a short run: 8+2+3+2 = 15 pixels/line, 6+2+2+2 = 12 lines/frame.
// hsync pixels 10..12, vsync lines 8..9. Instance dut uses CLK_DIV=2
// (frame = 360 clks), dut1 uses CLK_DIV=1 (frame = 180 clks).
module tb_vga_scan_gen;

  localparam int HV = 8, HF = 2, HS = 3, HB = 2;
  localparam int VV = 6, VF = 2, VS = 2, VB = 2;
  localparam int HT = 15, VT = 12, FT = 180;
`ifdef VGA_PIPE_ALIGN_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  logic       clk;
  logic       Reset;
  logic       pix_en, hs, vs, blank, frame_start, vblank_start;
  logic [9:0] DrawX, DrawY;
  logic       pix_en_1, hs_1, vs_1, blank_1, frame_start_1, vblank_start_1;
  logic [9:0] DrawX_1, DrawY_1;

  int checks   = 0;
  int failures = 0;
  int kc       = 0;   // negedges since the last reset release

  vga_scan_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .CLK_DIV(2)
  ) dut (
    .clk(clk), .Reset(Reset), .pix_en(pix_en), .DrawX(DrawX), .DrawY(DrawY),
    .hs(hs), .vs(vs), .blank(blank), .frame_start(frame_start),
    .vblank_start(vblank_start)
  );

  vga_scan_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .CLK_DIV(1)
  ) dut1 (
    .clk(clk), .Reset(Reset), .pix_en(pix_en_1), .DrawX(DrawX_1), .DrawY(DrawY_1),
    .hs(hs_1), .vs(vs_1), .blank(blank_1), .frame_start(frame_start_1),
    .vblank_start(vblank_start_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected behaviour as a function of negedge index k after reset release.
  // After edge j the divider holds j mod div; the raster advances on edges
  // k >= 2 with k mod div == 0.
  function automatic int pix_of(int k, int div);
    if (div == 1) return (k >= 1) ? k - 1 : 0;
    return k / div;
  endfunction
  function automatic bit pen_exp(int k, int div);
    if (div == 1) return k >= 1;
    return (k % div) == div - 1;
  endfunction
  function automatic bit adv_edge(int k, int div);
    return (k >= 2) && ((k % div) == 0);
  endfunction
  function automatic bit hs_exp(int p);
    int q = PIPE ? p - 1 : p;
    int x;
    if (q < 0) return 1'b1;
    x = q % HT;
    return !(x >= HV + HF && x <= HV + HF + HS - 1);
  endfunction
  function automatic bit vs_exp(int p);
    int q = PIPE ? p - 1 : p;
    int y;
    if (q < 0) return 1'b1;
    y = (q / HT) % VT;
    return !(y >= VV + VF && y <= VV + VF + VS - 1);
  endfunction
  function automatic bit blank_exp(int p);
    int q = PIPE ? p - 1 : p;
    if (q < 0) return 1'b1;
    return ((q % HT) < HV) && (((q / HT) % VT) < VV);
  endfunction
  function automatic bit fs_exp(int k, int div);
    return adv_edge(k, div) && (pix_of(k, div) % FT == 0);
  endfunction
  function automatic bit vb_exp(int k, int div);
    return adv_edge(k, div) && (pix_of(k, div) % FT == VV * HT);
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    kc++;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (DrawX !== 10'd0) begin failures++; $display("FAIL rst_drawx got=%0d exp=0", DrawX); end
    checks++; if (DrawY !== 10'd0) begin failures++; $display("FAIL rst_drawy got=%0d exp=0", DrawY); end
    checks++; if (hs !== 1'b1) begin failures++; $display("FAIL rst_hs got=%b exp=1", hs); end
    checks++; if (vs !== 1'b1) begin failures++; $display("FAIL rst_vs got=%b exp=1", vs); end
    checks++; if (blank !== 1'b1) begin failures++; $display("FAIL rst_blank got=%b exp=1", blank); end
    checks++; if (pix_en !== 1'b0) begin failures++; $display("FAIL rst_pix_en got=%b exp=0", pix_en); end
    checks++; if (frame_start !== 1'b0 || vblank_start !== 1'b0) begin
      failures++; $display("FAIL rst_pulses got=%b%b exp=00", frame_start, vblank_start); end
    checks++; if (pix_en_1 !== 1'b0) begin failures++; $display("FAIL rst_pix_en_div1 got=%b exp=0", pix_en_1); end
    Reset = 1'b0;
    kc = 0;
    step();
    checks++; if (pix_en !== 1'b1) begin failures++; $display("FAIL first_pix_en got=%b exp=1", pix_en); end
    checks++; if (DrawX !== 10'd0) begin failures++; $display("FAIL first_drawx_hold got=%0d exp=0", DrawX); end
    checks++; if (pix_en_1 !== 1'b1) begin failures++; $display("FAIL first_pix_en_div1 got=%b exp=1", pix_en_1); end
    step();
    checks++; if (DrawX !== 10'd1) begin failures++; $display("FAIL first_advance got=%0d exp=1", DrawX); end
    checks++; if (pix_en !== 1'b0) begin failures++; $display("FAIL pix_en_drop got=%b exp=0", pix_en); end
    checks++; if (DrawX_1 !== 10'd1) begin failures++; $display("FAIL first_advance_div1 got=%0d exp=1", DrawX_1); end
    checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL no_fs_after_reset got=%b exp=0", frame_start); end
    $display("test_reset done checks=%0d", checks);
  endtask

  // Two full lines plus a little: hsync window, blank edge, line wrap.
  task automatic test_line();
    int p;
    while (kc < 2 * HT * 2 + 6) begin
      step();
      p = pix_of(kc, 2);
      checks++; if (DrawX !== 10'(p % HT)) begin failures++; $display("FAIL line_drawx k=%0d got=%0d exp=%0d", kc, DrawX, p % HT); end
      checks++; if (DrawY !== 10'((p / HT) % VT)) begin failures++; $display("FAIL line_drawy k=%0d got=%0d exp=%0d", kc, DrawY, (p / HT) % VT); end
      checks++; if (hs !== hs_exp(p)) begin failures++; $display("FAIL line_hs k=%0d x=%0d got=%b exp=%b", kc, DrawX, hs, hs_exp(p)); end
      checks++; if (blank !== blank_exp(p)) begin failures++; $display("FAIL line_blank k=%0d x=%0d got=%b exp=%b", kc, DrawX, blank, blank_exp(p)); end
      checks++; if (pix_en !== pen_exp(kc, 2)) begin failures++; $display("FAIL line_pix_en k=%0d got=%b exp=%b", kc, pix_en, pen_exp(kc, 2)); end
    end
    $display("test_line done checks=%0d", checks);
  endtask

  // Three frames: vsync window, vblank pulse, frame period and pulse width.
  task automatic test_frames();
    int p;
    int last_fs = -1;
    int nfs = 0, nvb = 0, nfs_exp = 0, nvb_exp = 0;
    repeat (3 * FT * 2) begin
      step();
      p = pix_of(kc, 2);
      if (fs_exp(kc, 2)) nfs_exp++;
      if (vb_exp(kc, 2)) nvb_exp++;
      checks++; if (DrawY !== 10'((p / HT) % VT)) begin failures++; $display("FAIL frm_drawy k=%0d got=%0d exp=%0d", kc, DrawY, (p / HT) % VT); end
      checks++; if (DrawX !== 10'(p % HT)) begin failures++; $display("FAIL frm_drawx k=%0d got=%0d exp=%0d", kc, DrawX, p % HT); end
      checks++; if (vs !== vs_exp(p)) begin failures++; $display("FAIL frm_vs k=%0d y=%0d got=%b exp=%b", kc, DrawY, vs, vs_exp(p)); end
      checks++; if (hs !== hs_exp(p)) begin failures++; $display("FAIL frm_hs k=%0d x=%0d got=%b exp=%b", kc, DrawX, hs, hs_exp(p)); end
      checks++; if (blank !== blank_exp(p)) begin failures++; $display("FAIL frm_blank k=%0d got=%b exp=%b", kc, blank, blank_exp(p)); end
      checks++; if (frame_start !== fs_exp(kc, 2)) begin failures++; $display("FAIL frm_frame_start k=%0d got=%b exp=%b", kc, frame_start, fs_exp(kc, 2)); end
      checks++; if (vblank_start !== vb_exp(kc, 2)) begin failures++; $display("FAIL frm_vblank_start k=%0d got=%b exp=%b", kc, vblank_start, vb_exp(kc, 2)); end
      if (frame_start === 1'b1) begin
        if (last_fs >= 0) begin
          checks++; if (kc - last_fs != FT * 2) begin failures++; $display("FAIL frm_period got=%0d exp=%0d", kc - last_fs, FT * 2); end
        end
        last_fs = kc;
        nfs++;
      end
      if (vblank_start === 1'b1) nvb++;
    end
    checks++; if (nfs != nfs_exp) begin failures++; $display("FAIL frm_fs_count got=%0d exp=%0d", nfs, nfs_exp); end
    checks++; if (nvb != nvb_exp) begin failures++; $display("FAIL frm_vb_count got=%0d exp=%0d", nvb, nvb_exp); end
    $display("test_frames done frame_starts=%0d vblank_starts=%0d", nfs, nvb);
  endtask

  // CLK_DIV = 1 instance: enable held high, half-length frame period.
  task automatic test_clk_div1();
    int p;
    int last_fs = -1;
    int nper = 0;
    repeat (2 * FT + 20) begin
      step();
      p = pix_of(kc, 1);
      checks++; if (pix_en_1 !== 1'b1) begin failures++; $display("FAIL div1_pix_en k=%0d got=%b exp=1", kc, pix_en_1); end
      checks++; if (DrawX_1 !== 10'(p % HT)) begin failures++; $display("FAIL div1_drawx k=%0d got=%0d exp=%0d", kc, DrawX_1, p % HT); end
      checks++; if (DrawY_1 !== 10'((p / HT) % VT)) begin failures++; $display("FAIL div1_drawy k=%0d got=%0d exp=%0d", kc, DrawY_1, (p / HT) % VT); end
      checks++; if (hs_1 !== hs_exp(p) || vs_1 !== vs_exp(p) || blank_1 !== blank_exp(p)) begin
        failures++; $display("FAIL div1_syncs k=%0d got=%b%b%b exp=%b%b%b", kc, hs_1, vs_1, blank_1, hs_exp(p), vs_exp(p), blank_exp(p)); end
      checks++; if (frame_start_1 !== fs_exp(kc, 1)) begin failures++; $display("FAIL div1_frame_start k=%0d got=%b exp=%b", kc, frame_start_1, fs_exp(kc, 1)); end
      checks++; if (vblank_start_1 !== vb_exp(kc, 1)) begin failures++; $display("FAIL div1_vblank_start k=%0d got=%b exp=%b", kc, vblank_start_1, vb_exp(kc, 1)); end
      if (frame_start_1 === 1'b1) begin
        if (last_fs >= 0) begin
          checks++; if (kc - last_fs != FT) begin failures++; $display("FAIL div1_period got=%0d exp=%0d", kc - last_fs, FT); end
          nper++;
        end
        last_fs = kc;
      end
    end
    checks++; if (nper < 1) begin failures++; $display("FAIL div1_period_seen got=%0d exp>=1", nper); end
    $display("test_clk_div1 done periods=%0d", nper);
  endtask

  // Reset pulse inside hsync and vsync, on a cycle where pix_en is also high.
  task automatic test_mid_reset();
    int n = 0;
    bit found = 1'b0;
    int p;
    while (!found && n < 1000) begin
      step();
      n++;
      if (DrawX == 10'd11 && DrawY == 10'd9 && pix_en) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("FAIL mid_reset_reach got=%0d,%0d exp=11,9", DrawX, DrawY); end
    checks++; if (hs !== 1'b0 || vs !== 1'b0) begin failures++; $display("FAIL mid_reset_pre_sync got=%b%b exp=00", hs, vs); end
    Reset = 1'b1;
    step();
    checks++; if (DrawX !== 10'd0 || DrawY !== 10'd0) begin failures++; $display("FAIL mid_reset_xy got=%0d,%0d exp=0,0", DrawX, DrawY); end
    checks++; if (hs !== 1'b1 || vs !== 1'b1 || blank !== 1'b1) begin failures++; $display("FAIL mid_reset_syncs got=%b%b%b exp=111", hs, vs, blank); end
    checks++; if (pix_en !== 1'b0 || frame_start !== 1'b0 || vblank_start !== 1'b0) begin
      failures++; $display("FAIL mid_reset_pulses got=%b%b%b exp=000", pix_en, frame_start, vblank_start); end
    Reset = 1'b0;
    kc = 0;
    repeat (2 * HT * 2) begin
      step();
      p = pix_of(kc, 2);
      checks++; if (DrawX !== 10'(p % HT) || DrawY !== 10'((p / HT) % VT)) begin
        failures++; $display("FAIL resume_xy k=%0d got=%0d,%0d exp=%0d,%0d", kc, DrawX, DrawY, p % HT, (p / HT) % VT); end
      checks++; if (hs !== hs_exp(p) || vs !== vs_exp(p) || blank !== blank_exp(p)) begin
        failures++; $display("FAIL resume_syncs k=%0d got=%b%b%b exp=%b%b%b", kc, hs, vs, blank, hs_exp(p), vs_exp(p), blank_exp(p)); end
      checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL resume_no_fs k=%0d got=%b exp=0", kc, frame_start); end
    end
    $display("test_mid_reset done checks=%0d", checks);
  endtask

  initial begin
    Reset = 1'b1;
    test_reset();
    test_line();
    test_frames();
    test_clk_div1();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
